// File: rtl/alu_issue_ctrl.sv
// Issue front-end for the 8-bit combinational ALU: decodes, reads operands from an 8x8 RF, writes back results.
// Latency: accept at edge A, result valid from A+1; one instruction in flight (IDLE/EXEC/DONE).
// Backpressure: in_ready only in IDLE; the result holds in DONE until out_ready.
module alu_issue_ctrl #(
    parameter int          DATA_W   = 8,
    parameter int          RF_DEPTH = 8,
    parameter logic [3:0]  IMM_OP   = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_rd,
    output logic              carry_flag,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] rf [RF_DEPTH];
    logic [3:0]        op_q;
    logic [2:0]        rd_q;

    logic [3:0]        op;
    logic [2:0]        rd;
    logic [2:0]        rs1;
    logic [2:0]        rs2;
    logic [7:0]        imm;

    assign op  = instr[15:12];
    assign rd  = instr[11:9];
    assign rs1 = instr[8:6];
    assign rs2 = instr[5:3];
    assign imm = instr[7:0];

    assign in_ready = (state == IDLE);
    assign dbg_data = rf[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf[i] <= '0;
            end
            op_q       <= '0;
            rd_q       <= '0;
            alu_ctrl   <= '0;
            alu_x      <= '0;
            alu_y      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_rd     <= '0;
            carry_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= op;
                        rd_q  <= rd;
                        state <= EXEC;
                        // Load-immediate bypasses the ALU; alu_x carries the immediate to writeback.
                        if (op == IMM_OP) begin
                            alu_ctrl <= 4'h0;
                            alu_x    <= imm;
                        end else begin
                            alu_ctrl <= op;
                            alu_x    <= rf[rs1];
                            alu_y    <= rf[rs2];
                        end
                    end
                end
                EXEC: begin
                    out_rd    <= rd_q;
                    out_valid <= 1'b1;
                    state     <= DONE;
                    if (op_q == IMM_OP) begin
                        rf[rd_q] <= alu_x;
                        out_data <= alu_x;
                    end else if (op_q <= 4'hC) begin
                        rf[rd_q] <= alu_out;
                        out_data <= alu_out;
                    end else begin
                        out_data <= '0;
                    end
                    // ALU carry is only meaningful for add and sub.
                    if (op_q == 4'h0 || op_q == 4'h1) begin
                        carry_flag <= alu_carry;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural model of the downstream 8-bit ALU.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [3:0]  alu_ctrl;
    logic [7:0]  alu_x;
    logic [7:0]  alu_y;
    logic [7:0]  alu_out;
    logic        alu_carry;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_rd;
    logic        carry_flag;
    logic [2:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .alu_ctrl   (alu_ctrl),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .carry_flag (carry_flag),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: carry is driven only for add/sub, 0 elsewhere.
    always_comb begin
        logic [8:0] wide;
        wide      = 9'h0;
        alu_out   = 8'h00;
        alu_carry = 1'b0;
        case (alu_ctrl)
            4'h0: begin wide = {1'b0, alu_x} + {1'b0, alu_y}; alu_out = wide[7:0]; alu_carry = wide[8]; end
            4'h1: begin wide = {1'b0, alu_x} - {1'b0, alu_y}; alu_out = wide[7:0]; alu_carry = wide[8]; end
            4'h2: alu_out = alu_x & alu_y;
            4'h3: alu_out = alu_x | alu_y;
            4'h4: alu_out = alu_x ^ alu_y;
            4'h5: alu_out = ~alu_x;
            4'h6: alu_out = alu_y >> alu_x[2:0];
            4'h7: alu_out = alu_y << alu_x[2:0];
            4'hC: alu_out = {7'h0, alu_x == alu_y};
            default: alu_out = 8'hA5;
        endcase
    end

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] mki(input logic [2:0] rd, input logic [7:0] imm);
        return {4'hF, rd, 1'b0, imm};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1 with the DUT in IDLE.
    task automatic run_op(input string tag, input logic [15:0] ins, input logic [7:0] ed,
                          input logic [2:0] erd, input logic ec);
        in_valid = 1'b1;
        instr    = ins;
        @(posedge clk); #1;
        in_valid = 1'b0;
        instr    = 16'h0000;
        chk({tag, " exec in_ready"}, {15'h0, in_ready}, 16'h0);
        chk({tag, " exec out_valid"}, {15'h0, out_valid}, 16'h0);
        @(posedge clk); #1;
        chk({tag, " out_valid"}, {15'h0, out_valid}, 16'h1);
        chk({tag, " out_data"}, {8'h0, out_data}, {8'h0, ed});
        chk({tag, " out_rd"}, {13'h0, out_rd}, {13'h0, erd});
        chk({tag, " carry_flag"}, {15'h0, carry_flag}, {15'h0, ec});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " idle out_valid"}, {15'h0, out_valid}, 16'h0);
        chk({tag, " idle in_ready"}, {15'h0, in_ready}, 16'h1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = 16'h0000;
        out_ready = 1'b0;
        dbg_addr  = 3'd0;

        // Reset state
        #12;
        chk("rst in_ready", {15'h0, in_ready}, 16'h1);
        chk("rst out_valid", {15'h0, out_valid}, 16'h0);
        chk("rst out_data", {8'h0, out_data}, 16'h0);
        chk("rst out_rd", {13'h0, out_rd}, 16'h0);
        chk("rst carry", {15'h0, carry_flag}, 16'h0);
        chk("rst alu_ctrl", {12'h0, alu_ctrl}, 16'h0);
        chk("rst alu_x", {8'h0, alu_x}, 16'h0);
        chk("rst alu_y", {8'h0, alu_y}, 16'h0);
        dbg_addr = 3'd5;
        #1;
        chk("rst rf5", {8'h0, dbg_data}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Loads and add/sub/and
        run_op("loadi r1", mki(3'd1, 8'hF0), 8'hF0, 3'd1, 1'b0);
        chk("loadi alu_ctrl", {12'h0, alu_ctrl}, 16'h0);
        chk("loadi alu_x", {8'h0, alu_x}, 16'h00F0);
        run_op("loadi r2", mki(3'd2, 8'h20), 8'h20, 3'd2, 1'b0);
        run_op("add r3", mk(4'h0, 3'd3, 3'd1, 3'd2), 8'h10, 3'd3, 1'b1);
        chk("add alu_x", {8'h0, alu_x}, 16'h00F0);
        chk("add alu_y", {8'h0, alu_y}, 16'h0020);
        dbg_addr = 3'd3;
        #1;
        chk("dbg rf3", {8'h0, dbg_data}, 16'h0010);
        run_op("sub r4", mk(4'h1, 3'd4, 3'd2, 3'd1), 8'h30, 3'd4, 1'b1);
        run_op("and r5", mk(4'h2, 3'd5, 3'd1, 3'd2), 8'h20, 3'd5, 1'b1);

        // Output stall: OR r6 held in DONE, a second instruction waits
        in_valid = 1'b1;
        instr    = mk(4'h3, 3'd6, 3'd1, 3'd2);
        @(posedge clk); #1;
        instr = mki(3'd0, 8'h55);
        chk("stall exec in_ready", {15'h0, in_ready}, 16'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall out_valid", {15'h0, out_valid}, 16'h1);
            chk("stall out_data", {8'h0, out_data}, 16'h00F0);
            chk("stall out_rd", {13'h0, out_rd}, 16'h6);
            chk("stall in_ready", {15'h0, in_ready}, 16'h0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release out_valid", {15'h0, out_valid}, 16'h0);
        chk("release in_ready", {15'h0, in_ready}, 16'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("held accept in_ready", {15'h0, in_ready}, 16'h0);
        @(posedge clk); #1;
        chk("held out_valid", {15'h0, out_valid}, 16'h1);
        chk("held out_data", {8'h0, out_data}, 16'h0055);
        chk("held out_rd", {13'h0, out_rd}, 16'h0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        dbg_addr = 3'd6;
        #1;
        chk("dbg rf6", {8'h0, dbg_data}, 16'h00F0);
        dbg_addr = 3'd0;
        #1;
        chk("dbg rf0", {8'h0, dbg_data}, 16'h0055);
        @(posedge clk); #1;

        // Shift and compare
        run_op("loadi r1 3", mki(3'd1, 8'h03), 8'h03, 3'd1, 1'b1);
        run_op("loadi r2 81", mki(3'd2, 8'h81), 8'h81, 3'd2, 1'b1);
        run_op("shl r3", mk(4'h7, 3'd3, 3'd1, 3'd2), 8'h08, 3'd3, 1'b1);
        run_op("eq r4", mk(4'hC, 3'd4, 3'd1, 3'd1), 8'h01, 3'd4, 1'b1);

        // Reserved op leaves rf and carry untouched
        run_op("rsvd r6", mk(4'hD, 3'd6, 3'd1, 3'd2), 8'h00, 3'd6, 1'b1);
        dbg_addr = 3'd6;
        #1;
        chk("rsvd rf6", {8'h0, dbg_data}, 16'h00F0);

        // Add without carry clears the sticky flag
        run_op("add r5", mk(4'h0, 3'd5, 3'd1, 3'd2), 8'h84, 3'd5, 1'b0);

        // Reset during EXEC discards the writeback
        in_valid = 1'b1;
        instr    = mk(4'h0, 3'd7, 3'd1, 3'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("midrst exec in_ready", {15'h0, in_ready}, 16'h0);
        rst_n = 1'b0;
        #1;
        dbg_addr = 3'd7;
        #1;
        chk("midrst out_valid", {15'h0, out_valid}, 16'h0);
        chk("midrst in_ready", {15'h0, in_ready}, 16'h1);
        chk("midrst rf7", {8'h0, dbg_data}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post rst in_ready", {15'h0, in_ready}, 16'h1);
        chk("post rst out_valid", {15'h0, out_valid}, 16'h0);
        chk("post rst rf7", {8'h0, dbg_data}, 16'h0);
        chk("post rst carry", {15'h0, carry_flag}, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential front-end for the combinational 8-bit ALU (4-bit ctrl, x, y in; out, carry back).
- Accepts 16-bit instructions over a valid/ready handshake and reads two operands from an internal 8x8 register file.
- Drives registered ctrl/x/y into the ALU, captures out/carry, writes the result back, and presents it on a valid/ready result port.
- Sits directly upstream of the ALU and also consumes its outputs.

Parameters:
- DATA_W, 8: datapath width; must equal the ALU width; only 8 is supported.
- RF_DEPTH, 8: register count; address width is fixed at 3.
- IMM_OP, 4'hF: opcode meaning "load immediate", which is not sent to the ALU.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction valid
- in_ready  output  1  instruction ready; high iff state==IDLE
- instr  input  16  [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2; for IMM_OP, [7:0] is imm
- alu_ctrl  output  4  to ALU ctrl
- alu_x  output  8  to ALU x
- alu_y  output  8  to ALU y
- alu_out  input  8  from ALU out
- alu_carry  input  1  from ALU carry
- out_valid  output  1  result valid
- out_ready  input  1  result consumer ready
- out_data  output  8  result value
- out_rd  output  3  destination register of the result
- carry_flag  output  1  sticky carry from the last add/sub
- dbg_addr  input  3  debug read address
- dbg_data  output  8  combinational read of rf[dbg_addr]

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE; all rf entries=0; carry_flag=0; alu_ctrl=0; alu_x=0; alu_y=0; out_valid=0; out_data=0; out_rd=0. in_ready=1 while in reset, since state is IDLE.
- FSM states:
  - IDLE -> EXEC on in_valid&&in_ready (edge A). At A, latch: alu_ctrl<=op, alu_x<=rf[rs1], alu_y<=rf[rs2], rd/op held internally. For IMM_OP, latch alu_x<=imm and alu_ctrl<=4'h0.
  - EXEC -> DONE at the next edge (A+1). The ALU evaluates combinationally from the registered inputs during EXEC.
  - At A+1:
    - Ops 0000-1100: rf[rd]<=alu_out, out_data<=alu_out.
    - IMM_OP: rf[rd]<=imm, out_data<=imm.
    - Ops 1101-1110 are reserved: no rf write, out_data<=0.
    - In all cases out_rd<=rd and out_valid<=1.
  - carry_flag<=alu_carry only for ops 0000 and 0001. All other ops hold carry_flag, because the ALU's carry output is not defined for them.
  - DONE: out_valid=1 and out_data/out_rd are stable. DONE -> IDLE on out_ready, and out_valid<=0 at that edge.
- Latency: accept at edge A, out_valid high from A+1. Minimum issue interval is 3 cycles (IDLE/EXEC/DONE) with out_ready held high.
- in_ready is low in EXEC and DONE. in_valid there is ignored; the instruction is not consumed and instr may change.
- Hazards: execution is serial, so there are no RAW hazards. An instruction reading the rd of the previous instruction sees the written value.
- rd==rs1 or rd==rs2 is legal. Operands are sampled before the write.
- alu_ctrl/x/y hold their last values in IDLE and DONE. They are never driven combinationally from instr.
- Shift ops use alu_x[2:0] as the shift amount; the block applies no masking of its own.
- Reset mid-operation (EXEC or DONE): return immediately to reset values. The pending writeback is discarded. out_valid drops asynchronously.
- dbg_data reflects an rf write starting from the edge after the write.

Test Plan:
- Reset, then LOADI r1=0xF0 and LOADI r2=0x20, then ADD r3=r1+r2 -> out_data=0x10, out_rd=3, carry_flag=1, dbg rf[3]=0x10, out_valid exactly 1 cycle after accept.
- SUB r4=r2-r1 (0x20-0xF0) -> out_data=0x30, carry_flag=1; then AND r5=r1&r2 -> 0x20 with carry_flag still 1.
- Hold out_ready=0 for 5 cycles after result -> out_valid, out_data and out_rd stable; in_ready=0; a presented instruction is not accepted until the cycle after out_ready=1.
- SHL (0111) with rf[x]=0x03, rf[y]=0x81 -> out_data=0x08. EQ (1100) r1,r1 -> out_data=0x01.
- Reserved op 1101 with rd=6 -> rf[6] unchanged, out_valid pulses with out_data=0, carry_flag unchanged.
- Assert rst_n=0 during EXEC of ADD r7 -> no write to r7 (dbg rf[7]=0), out_valid=0, in_ready=1 after release.
